flash_ctrl: RTL and testbench

Sequencer that generates the one-cycle enable strobes driving the 4-LED flash datapath (its i_enable input).
- Run mode: continuous strobes at one of four selectable rates.
- Burst mode: a programmed count of strobes, then a completion flag.
- Sits between board switches/buttons and the flash block; one instance per flash block.

---
 rtl/flash_ctrl_pkg.sv | 19 +
 rtl/flash_prescaler.sv | 40 ++++
 rtl/flash_ctrl.sv | 129 ++++++++++++
 tb/tb_flash_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared state encodings and default rate limits for the flash strobe sequencer.
package flash_ctrl_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_NB_COUNT = 8;
    localparam int DEF_LIMIT_0  = 7;
    localparam int DEF_LIMIT_1  = 15;
    localparam int DEF_LIMIT_2  = 31;
    localparam int DEF_LIMIT_3  = 63;

endpackage

// File: rtl/flash_prescaler.sv
// Rate prescaler: counts while active and emits a tick on the terminal count.
// The terminal count is re-latched only on clear or on a wrap.
module flash_prescaler
    import flash_ctrl_pkg::*;
#(
    parameter int NB_COUNT = DEF_NB_COUNT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                active,
    input  logic [NB_COUNT-1:0] limit,
    output logic                tick
);

    logic [NB_COUNT-1:0] count;
    logic [NB_COUNT-1:0] limit_q;

    assign tick = active && (count == limit_q);

    // A new limit takes effect only at a period boundary, so speed changes
    // never truncate or stretch the period in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            limit_q <= NB_COUNT'(DEF_LIMIT_0);
        end else if (clear) begin
            count   <= '0;
            limit_q <= limit;
        end else if (active) begin
            if (count == limit_q) begin
                count   <= '0;
                limit_q <= limit;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_ctrl.sv
// Strobe sequencer for the 4-LED flash datapath: continuous run mode at one of
// four rates, or a counted burst followed by a one-cycle completion flag.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int NB_COUNT = DEF_NB_COUNT,
    parameter int LIMIT_0  = DEF_LIMIT_0,
    parameter int LIMIT_1  = DEF_LIMIT_1,
    parameter int LIMIT_2  = DEF_LIMIT_2,
    parameter int LIMIT_3  = DEF_LIMIT_3
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic [1:0]          i_speed,
    input  logic                i_burst,
    input  logic [NB_COUNT-1:0] i_burst_len,
    output logic                o_enable,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_state
);

    generate
        if (LIMIT_0 >= (1 << NB_COUNT) || LIMIT_1 >= (1 << NB_COUNT) ||
            LIMIT_2 >= (1 << NB_COUNT) || LIMIT_3 >= (1 << NB_COUNT)) begin : g_bad_limit
            $error("flash_ctrl: every LIMIT_x must fit in NB_COUNT bits");
        end
    endgenerate

    function automatic logic [NB_COUNT-1:0] speed_limit(input logic [1:0] speed);
        case (speed)
            2'd0:    return NB_COUNT'(LIMIT_0);
            2'd1:    return NB_COUNT'(LIMIT_1);
            2'd2:    return NB_COUNT'(LIMIT_2);
            default: return NB_COUNT'(LIMIT_3);
        endcase
    endfunction

    state_t              state;
    state_t              next_state;
    logic [NB_COUNT-1:0] remaining;
    logic                load_rem;
    logic                dec_rem;
    logic                enable_next;
    logic                clear;
    logic                active;
    logic                tick;

    assign active  = (state == ST_RUN) || (state == ST_BURST);
    assign o_state = state;

    flash_prescaler #(
        .NB_COUNT (NB_COUNT)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (i_reset),
        .clear   (clear),
        .active  (active),
        .limit   (speed_limit(i_speed)),
        .tick    (tick)
    );

    always_comb begin
        next_state  = state;
        load_rem    = 1'b0;
        dec_rem     = 1'b0;
        enable_next = 1'b0;
        clear       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Holding clear in IDLE zeroes the count and latches the
                // requested speed on the very cycle we leave.
                clear = 1'b1;
                if (i_burst) begin
                    if (i_burst_len != '0) begin
                        next_state = ST_BURST;
                        load_rem   = 1'b1;
                    end else begin
                        next_state = ST_DONE;
                    end
                end else if (i_run) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_run) begin
                    next_state = ST_IDLE;
                    clear      = 1'b1;
                end else begin
                    enable_next = tick;
                end
            end
            ST_BURST: begin
                if (tick) begin
                    enable_next = 1'b1;
                    dec_rem     = 1'b1;
                    if (remaining == NB_COUNT'(1)) begin
                        next_state = ST_DONE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            o_enable  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state    <= next_state;
            o_enable <= enable_next;
            o_busy   <= (next_state == ST_RUN) || (next_state == ST_BURST);
            o_done   <= (next_state == ST_DONE);
            if (load_rem) begin
                remaining <= i_burst_len;
            end else if (dec_rem) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// Scoreboard bench for flash_ctrl: expected strobe/done events are queued with
// their cycle numbers when stimulus is applied and matched as they appear.
module tb_flash_ctrl;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_run = 1'b0;
    logic [1:0] i_speed = 2'd0;
    logic       i_burst = 1'b0;
    logic [7:0] i_burst_len = 8'd0;
    logic       o_enable;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_state;

    typedef struct {
        int         cyc;
        logic [1:0] ev;
    } ev_t;

    ev_t sb[$];
    ev_t e;
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  c0;
    int  b;

    flash_ctrl dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_run       (i_run),
        .i_speed     (i_speed),
        .i_burst     (i_burst),
        .i_burst_len (i_burst_len),
        .o_enable    (o_enable),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input logic [1:0] ev);
        sb.push_back('{c, ev});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic peek();
        @(negedge clock);
    endtask

    // Event codes are {o_enable, o_done}.
    always @(negedge clock) begin
        if (i_reset && (o_enable || o_done)) begin
            if (sb.size() == 0) begin
                check("spurious_ev", {30'd0, o_enable, o_done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ev_cyc", cyc, e.cyc);
                check("ev_kind", {30'd0, o_enable, o_done}, {30'd0, e.ev});
            end
        end
    end

    initial begin
        step(3);
        peek();
        check("rst_state", o_state, 0);
        check("rst_busy", o_busy, 0);
        check("rst_enable", o_enable, 0);
        check("rst_done", o_done, 0);
        step(1);
        i_reset = 1'b1;
        step(2);

        // Continuous run at speed 0: strobes every 8 cycles from cycle 8.
        c0 = cyc;
        i_run = 1'b1;
        i_speed = 2'd0;
        for (int k = 1; k <= 16; k++) expect_ev(c0 + 1 + 8 * k, 2'b10);
        step(1);
        peek();
        check("run_busy", o_busy, 1);
        check("run_state", o_state, 1);
        step(128);
        i_run = 1'b0;
        step(1);
        peek();
        check("run_stop_state", o_state, 0);
        check("run_stop_busy", o_busy, 0);

        // Speed 0 -> 3 while the prescaler is at 3.
        step(1);
        c0 = cyc;
        i_run = 1'b1;
        i_speed = 2'd0;
        expect_ev(c0 + 1 + 8, 2'b10);
        expect_ev(c0 + 1 + 72, 2'b10);
        expect_ev(c0 + 1 + 136, 2'b10);
        step(4);
        i_speed = 2'd3;
        step(196);
        i_run = 1'b0;
        step(1);
        peek();
        check("spd_stop_state", o_state, 0);

        // Burst of 5 at speed 1.
        step(1);
        c0 = cyc;
        b = c0 + 1;
        i_burst = 1'b1;
        i_burst_len = 8'd5;
        i_speed = 2'd1;
        for (int k = 1; k <= 4; k++) expect_ev(b + 16 * k, 2'b10);
        expect_ev(b + 80, 2'b11);
        step(1);
        i_burst = 1'b0;
        peek();
        check("burst_state", o_state, 2);
        check("burst_busy", o_busy, 1);
        step(80);
        peek();
        check("burst_done_state", o_state, 3);
        check("burst_done_busy", o_busy, 0);
        step(1);
        peek();
        check("burst_idle_state", o_state, 0);
        check("burst_idle_busy", o_busy, 0);

        // Zero-length burst: DONE only.
        step(1);
        c0 = cyc;
        i_burst = 1'b1;
        i_burst_len = 8'd0;
        expect_ev(c0 + 1, 2'b01);
        step(1);
        i_burst = 1'b0;
        peek();
        check("zero_done_state", o_state, 3);
        step(1);
        peek();
        check("zero_idle_state", o_state, 0);

        // Burst wins over run; run resumes once back in IDLE.
        step(1);
        c0 = cyc;
        b = c0 + 1;
        i_burst = 1'b1;
        i_burst_len = 8'd2;
        i_run = 1'b1;
        i_speed = 2'd0;
        expect_ev(b + 8, 2'b10);
        expect_ev(b + 16, 2'b11);
        step(1);
        i_burst = 1'b0;
        peek();
        check("prio_state", o_state, 2);
        step(16);
        peek();
        check("prio_done_state", o_state, 3);
        step(1);
        peek();
        check("prio_idle_state", o_state, 0);
        step(1);
        i_run = 1'b0;
        peek();
        check("prio_run_state", o_state, 1);
        step(1);
        peek();
        check("prio_end_state", o_state, 0);

        // Asynchronous reset mid-burst (remaining 3, prescaler 4).
        step(1);
        c0 = cyc;
        b = c0 + 1;
        i_burst = 1'b1;
        i_burst_len = 8'd5;
        i_speed = 2'd1;
        expect_ev(b + 16, 2'b10);
        expect_ev(b + 32, 2'b10);
        step(1);
        i_burst = 1'b0;
        step(36);
        i_reset = 1'b0;
        #2;
        check("arst_state", o_state, 0);
        check("arst_busy", o_busy, 0);
        check("arst_enable", o_enable, 0);
        check("arst_done", o_done, 0);
        step(2);
        i_reset = 1'b1;
        step(40);
        peek();
        check("post_rst_state", o_state, 0);
        check("post_rst_busy", o_busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
